grouped_mac_accum: RTL and testbench

- Multi-beat successor to the single-shot grouped MAC.
- Performs LANES signed int8 multiplies per beat and reduces them into up to MAX_GROUPS contiguous lane groups of configurable size.
- Accumulates each group's sum over a configured number of beats, with saturation, and returns one result vector per job.
- Sits between the operand fetch/buffer stage and the requantisation stage, using valid/ready handshakes on all three interfaces.

---
 rtl/mac_pkg.sv | 26 ++
 rtl/group_reduce.sv | 37 +++
 rtl/grouped_mac_accum.sv | 184 ++++++++++++++++++
 tb/tb_grouped_mac_accum.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared FSM state, derived widths and the saturating accumulate used by grouped_mac_accum.
package mac_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FLUSH, ST_OUT} state_t;

  localparam int MAC_DATA_WIDTH = 8;
  localparam int MAC_MAX_GROUPS = 8;
  localparam int PROD_W         = 2 * MAC_DATA_WIDTH;
  localparam int GRP_CNT_W      = $clog2(MAC_MAX_GROUPS + 1);

  // Returns {clamped, value}: a+b clamped to a signed acc_w-bit range, held sign-extended in 64 bits.
  function automatic logic [64:0] sat_add(input logic signed [63:0] a,
                                          input logic signed [63:0] b,
                                          input int acc_w);
    logic signed [64:0] s;
    logic signed [64:0] hi;
    logic signed [64:0] lo;
    s  = {a[63], a} + {b[63], b};
    hi = (65'sd1 <<< (acc_w - 1)) - 65'sd1;
    lo = -(65'sd1 <<< (acc_w - 1));
    if (s > hi)      return {1'b1, hi[63:0]};
    else if (s < lo) return {1'b1, lo[63:0]};
    else             return {1'b0, s[63:0]};
  endfunction

endpackage

// File: rtl/group_reduce.sv
// Sums the products of one contiguous lane window [start, start+count) into a registered signed total.
// One cycle latency when en is high; the sum holds otherwise.
module group_reduce
  import mac_pkg::*;
#(
  parameter int LANES      = 64,
  parameter int LANE_CNT_W = 7,
  parameter int SUM_W      = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [LANES*PROD_W-1:0]  prods,
  input  logic [LANE_CNT_W-1:0]    start,
  input  logic [LANE_CNT_W-1:0]    count,
  output logic signed [SUM_W-1:0]  sum
);

  logic [LANE_CNT_W:0]     stop;
  logic signed [SUM_W-1:0] tree;

  assign stop = {1'b0, start} + {1'b0, count};

  always_comb begin
    tree = '0;
    for (int i = 0; i < LANES; i++) begin
      if (i >= int'(start) && i < int'(stop))
        tree = tree + SUM_W'($signed(prods[i*PROD_W +: PROD_W]));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    sum <= '0;
    else if (en) sum <= tree;
  end

endmodule

// File: rtl/grouped_mac_accum.sv
// Multi-beat grouped int8 MAC: per-beat products reduced into lane groups and saturating-accumulated per job.
// Last beat to out_valid is 4 cycles; one beat per cycle in RUN, result held in OUT until out_ready.
module grouped_mac_accum
  import mac_pkg::*;
#(
  parameter int LANES      = 64,
  parameter int DATA_WIDTH = MAC_DATA_WIDTH,
  parameter int MAX_GROUPS = MAC_MAX_GROUPS,
  parameter int LANE_CNT_W = 7,
  parameter int ACC_WIDTH  = 32,
  parameter int BEAT_W     = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             cfg_valid,
  output logic                             cfg_ready,
  input  logic [GRP_CNT_W-1:0]             cfg_num_groups,
  input  logic [MAX_GROUPS*LANE_CNT_W-1:0] cfg_group_lanes,
  input  logic [BEAT_W-1:0]                cfg_num_beats,
  output logic                             cfg_err,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [LANES*DATA_WIDTH-1:0]      in_data,
  input  logic [LANES*DATA_WIDTH-1:0]      in_weight,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [MAX_GROUPS*ACC_WIDTH-1:0]  out_data,
  output logic [GRP_CNT_W-1:0]             out_num_groups,
  output logic [MAX_GROUPS-1:0]            out_overflow,
  output logic                             busy
);

  localparam int TREE_W = PROD_W + $clog2(LANES) + 1;
  // Group sums are kept at least wide enough for a full-lane beat so narrow accumulators clamp instead of wrapping.
  localparam int GS_W   = (ACC_WIDTH > TREE_W) ? ACC_WIDTH : TREE_W;
  localparam int CSUM_W = LANE_CNT_W + GRP_CNT_W;

  state_t                               state_q, state_d;
  logic [GRP_CNT_W-1:0]                 num_groups_q;
  logic [MAX_GROUPS-1:0][LANE_CNT_W-1:0] start_q, lanes_q;
  logic [BEAT_W-1:0]                    beats_q, beat_cnt_q;
  logic                                 s1_vld, s2_vld, cfg_err_q;
  logic [LANES*PROD_W-1:0]              prod_q;
  logic signed [GS_W-1:0]               gsum [MAX_GROUPS];
  logic [MAX_GROUPS-1:0][ACC_WIDTH-1:0] acc_q, acc_nxt, out_data_q;
  logic [MAX_GROUPS-1:0]                ovf_q, clamp;
  logic [64:0]                          sat_r;
  logic [CSUM_W-1:0]                    pre [MAX_GROUPS];
  logic [CSUM_W-1:0]                    lane_total;
  logic                                 lanes_nz, cfg_ok;
  logic                                 cfg_acc, beat_acc, beat_last, drained;

  always_comb begin
    pre        = '{default: '0};
    lane_total = '0;
    lanes_nz   = 1'b1;
    for (int g = 0; g < MAX_GROUPS; g++) begin
      pre[g] = lane_total;
      if (g < int'(cfg_num_groups)) begin
        if (cfg_group_lanes[g*LANE_CNT_W +: LANE_CNT_W] == '0) lanes_nz = 1'b0;
        lane_total = lane_total + CSUM_W'(cfg_group_lanes[g*LANE_CNT_W +: LANE_CNT_W]);
      end
    end
    cfg_ok = lanes_nz && (cfg_num_groups != '0) && (int'(cfg_num_groups) <= MAX_GROUPS) &&
             (lane_total <= CSUM_W'(LANES));
  end

  assign cfg_acc   = (state_q == ST_IDLE) && cfg_valid && cfg_ok;
  assign beat_acc  = (state_q == ST_RUN) && in_valid;
  assign beat_last = (beat_cnt_q == beats_q - BEAT_W'(1));
  assign drained   = !s1_vld && !s2_vld;

  always_comb begin
    state_d   = state_q;
    cfg_ready = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        cfg_ready = 1'b1;
        busy      = 1'b0;
        if (cfg_acc) state_d = ST_RUN;
      end
      ST_RUN: begin
        in_ready = 1'b1;
        if (beat_acc && beat_last) state_d = ST_FLUSH;
      end
      ST_FLUSH: if (drained) state_d = ST_OUT;
      ST_OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      num_groups_q <= '0;
      start_q      <= '0;
      lanes_q      <= '0;
      beats_q      <= '0;
      beat_cnt_q   <= '0;
      cfg_err_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cfg_err_q <= (state_q == ST_IDLE) && cfg_valid && !cfg_ok;
      if (cfg_acc) begin
        num_groups_q <= cfg_num_groups;
        beats_q      <= (cfg_num_beats == '0) ? BEAT_W'(1) : cfg_num_beats;
        beat_cnt_q   <= '0;
        // Inactive groups get a zero lane count so their reducers always produce 0.
        for (int g = 0; g < MAX_GROUPS; g++) begin
          start_q[g] <= pre[g][LANE_CNT_W-1:0];
          lanes_q[g] <= (g < int'(cfg_num_groups)) ? cfg_group_lanes[g*LANE_CNT_W +: LANE_CNT_W] : '0;
        end
      end else if (beat_acc) begin
        beat_cnt_q <= beat_cnt_q + BEAT_W'(1);
      end
    end
  end

  for (genvar g = 0; g < MAX_GROUPS; g++) begin : g_grp
    group_reduce #(
      .LANES     (LANES),
      .LANE_CNT_W(LANE_CNT_W),
      .SUM_W     (GS_W)
    ) u_reduce (
      .clk  (clk),
      .rst  (rst),
      .en   (s1_vld),
      .prods(prod_q),
      .start(start_q[g]),
      .count(lanes_q[g]),
      .sum  (gsum[g])
    );
  end

  always_comb begin
    sat_r   = '0;
    acc_nxt = '0;
    clamp   = '0;
    for (int g = 0; g < MAX_GROUPS; g++) begin
      sat_r      = sat_add(64'($signed(acc_q[g])), 64'(gsum[g]), ACC_WIDTH);
      acc_nxt[g] = sat_r[ACC_WIDTH-1:0];
      clamp[g]   = sat_r[64];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_vld     <= 1'b0;
      s2_vld     <= 1'b0;
      prod_q     <= '0;
      acc_q      <= '0;
      ovf_q      <= '0;
      out_data_q <= '0;
    end else begin
      s1_vld <= beat_acc;
      s2_vld <= s1_vld;
      if (beat_acc) begin
        for (int i = 0; i < LANES; i++)
          prod_q[i*PROD_W +: PROD_W] <= PROD_W'($signed(in_data[i*DATA_WIDTH +: DATA_WIDTH])) *
                                        PROD_W'($signed(in_weight[i*DATA_WIDTH +: DATA_WIDTH]));
      end
      if (cfg_acc) begin
        acc_q <= '0;
        ovf_q <= '0;
      end else if (s2_vld) begin
        acc_q <= acc_nxt;
        ovf_q <= ovf_q | clamp;
      end
      if (state_q == ST_FLUSH && drained) out_data_q <= acc_q;
    end
  end

  assign out_data       = out_data_q;
  assign out_num_groups = num_groups_q;
  assign out_overflow   = ovf_q;
  assign cfg_err        = cfg_err_q;

endmodule

// File: tb/tb_grouped_mac_accum.sv
// Directed bench for grouped_mac_accum: default instance plus a 20-bit accumulator instance sharing all inputs.
module tb_grouped_mac_accum;

  logic         clk = 1'b0;
  logic         rst;
  logic         cfg_valid;
  logic [3:0]   cfg_num_groups;
  logic [55:0]  cfg_group_lanes;
  logic [15:0]  cfg_num_beats;
  logic         in_valid;
  logic [511:0] in_data, in_weight;
  logic         out_ready;

  logic         cfg_ready, cfg_err, in_ready, out_valid, busy;
  logic [255:0] out_data;
  logic [3:0]   out_num_groups;
  logic [7:0]   out_overflow;

  logic         b_cfg_ready, b_cfg_err, b_in_ready, b_out_valid, b_busy;
  logic [159:0] b_out_data;
  logic [3:0]   b_out_num_groups;
  logic [7:0]   b_out_overflow;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int acc_cyc;
  int out_lat;
  logic [511:0] d;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  grouped_mac_accum dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_num_groups(cfg_num_groups),
    .cfg_group_lanes(cfg_group_lanes), .cfg_num_beats(cfg_num_beats), .cfg_err(cfg_err),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_weight(in_weight),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_num_groups(out_num_groups), .out_overflow(out_overflow), .busy(busy)
  );

  grouped_mac_accum #(.ACC_WIDTH(20)) dut_narrow (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(b_cfg_ready), .cfg_num_groups(cfg_num_groups),
    .cfg_group_lanes(cfg_group_lanes), .cfg_num_beats(cfg_num_beats), .cfg_err(b_cfg_err),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data), .in_weight(in_weight),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
    .out_num_groups(b_out_num_groups), .out_overflow(b_out_overflow), .busy(b_busy)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic logic [511:0] fill(input logic [7:0] b);
    return {64{b}};
  endfunction

  function automatic logic [511:0] ramp();
    logic [511:0] r;
    for (int i = 0; i < 64; i++) r[i*8 +: 8] = 8'(i);
    return r;
  endfunction

  function automatic logic [55:0] lanes_of(input int a, input int b, input int c, input int e);
    logic [55:0] l;
    l = '0;
    l[6:0] = 7'(a); l[13:7] = 7'(b); l[20:14] = 7'(c); l[27:21] = 7'(e);
    return l;
  endfunction

  function automatic longint grp(input int g);
    return longint'($signed(out_data[g*32 +: 32]));
  endfunction

  function automatic longint bgrp0();
    return longint'($signed(b_out_data[19:0]));
  endfunction

  task automatic run_cfg(input int ng, input logic [55:0] ln, input int nb);
    cfg_num_groups = 4'(ng); cfg_group_lanes = ln; cfg_num_beats = 16'(nb); cfg_valid = 1'b1;
    for (int i = 0; i < 50 && !cfg_ready; i++) @(negedge clk);
    if (!cfg_ready) check("cfg_accept_timeout", 0, 1);
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic drive_beat(input logic [511:0] dv, input logic [511:0] wv, input int gap);
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_data = dv; in_weight = wv; in_valid = 1'b1;
    for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
    if (!in_ready) check("beat_accept_timeout", 0, 1);
    acc_cyc = cyc;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out();
    for (int i = 0; i < 50 && !out_valid; i++) @(negedge clk);
    if (!out_valid) check("out_valid_timeout", 0, 1);
    out_lat = cyc - acc_cyc;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b0; cfg_valid = 1'b0; cfg_num_groups = '0; cfg_group_lanes = '0; cfg_num_beats = '0;
    in_valid = 1'b0; in_data = '0; in_weight = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cfg_ready", cfg_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_data", (out_data == '0), 1);
    check("rst_cfg_err", cfg_err, 0);
    rst = 1'b1;
    @(negedge clk);

    // single group, 4 lanes; lanes beyond the group carry 9s that must be masked out
    d = fill(8'd9);
    d[7:0] = 8'd1; d[15:8] = 8'd2; d[23:16] = 8'd3; d[31:24] = 8'd4;
    run_cfg(1, lanes_of(4, 0, 0, 0), 1);
    check("t1_busy", busy, 1);
    check("t1_in_ready", in_ready, 1);
    drive_beat(d, fill(8'd1), 0);
    wait_out();
    check("t1_latency", out_lat, 4);
    check("t1_g0", grp(0), 10);
    check("t1_g1", grp(1), 0);
    check("t1_ovf", out_overflow, 0);
    check("t1_ngroups", out_num_groups, 1);
    handshake();
    check("t1_out_valid_drop", out_valid, 0);

    // two groups of 3 and 5 lanes, 4 beats of -128 x -128, then held output
    run_cfg(2, lanes_of(3, 5, 0, 0), 4);
    for (int b = 0; b < 4; b++) drive_beat(fill(8'h80), fill(8'h80), 0);
    wait_out();
    check("t2_latency", out_lat, 4);
    for (int k = 0; k < 10; k++) begin
      check("t2_hold_valid", out_valid, 1);
      check("t2_hold_g0", grp(0), 196608);
      check("t2_hold_in_ready", in_ready, 0);
      check("t2_hold_cfg_ready", cfg_ready, 0);
      @(negedge clk);
    end
    check("t2_g1", grp(1), 327680);
    check("t2_g2", grp(2), 0);
    check("t2_ngroups", out_num_groups, 2);
    cfg_num_groups = 4'd1; cfg_group_lanes = lanes_of(4, 0, 0, 0); cfg_num_beats = 16'd1;
    cfg_valid = 1'b1;
    handshake();
    cfg_valid = 1'b0;
    check("t2_out_valid_drop", out_valid, 0);
    check("t2_cfg_during_out_ignored", busy, 0);
    check("t2_g0_retained", grp(0), 196608);
    @(negedge clk);

    // three groups over a lane ramp, gap-free then with bubbles
    for (int pass = 0; pass < 2; pass++) begin
      run_cfg(3, lanes_of(2, 7, 10, 0), 3);
      drive_beat(ramp(), fill(8'd1), pass * 3);
      drive_beat(ramp(), fill(8'd2), pass * 1);
      drive_beat(ramp(), fill(8'hFF), pass * 4);
      wait_out();
      check("t3_latency", out_lat, 4);
      check("t3_g0", grp(0), 2);
      check("t3_g1", grp(1), 70);
      check("t3_g2", grp(2), 270);
      check("t3_g3", grp(3), 0);
      handshake();
    end

    // saturation on the 20-bit instance, both polarities
    run_cfg(1, lanes_of(64, 0, 0, 0), 2);
    drive_beat(fill(8'h7F), fill(8'h7F), 0);
    drive_beat(fill(8'h7F), fill(8'h7F), 0);
    wait_out();
    check("sat_pos_narrow", bgrp0(), 524287);
    check("sat_pos_narrow_ovf", b_out_overflow[0], 1);
    check("sat_pos_wide", grp(0), 2064512);
    check("sat_pos_wide_ovf", out_overflow, 0);
    handshake();
    run_cfg(1, lanes_of(64, 0, 0, 0), 2);
    drive_beat(fill(8'h80), fill(8'h7F), 0);
    drive_beat(fill(8'h80), fill(8'h7F), 0);
    wait_out();
    check("sat_neg_narrow", bgrp0(), -524288);
    check("sat_neg_narrow_ovf", b_out_overflow[0], 1);
    check("sat_neg_wide", grp(0), -2080768);
    handshake();

    // invalid configs: oversubscribed lanes, then an empty active group, then a valid one
    cfg_num_groups = 4'd2; cfg_group_lanes = lanes_of(40, 40, 0, 0); cfg_num_beats = 16'd1;
    cfg_valid = 1'b1;
    @(negedge clk);
    check("inv_sum_err", cfg_err, 1);
    check("inv_sum_busy", busy, 0);
    cfg_group_lanes = lanes_of(3, 0, 0, 0);
    @(negedge clk);
    check("inv_zero_err", cfg_err, 1);
    check("inv_zero_busy", busy, 0);
    cfg_num_groups = 4'd1; cfg_group_lanes = lanes_of(4, 0, 0, 0);
    @(negedge clk);
    cfg_valid = 1'b0;
    check("inv_then_valid_err", cfg_err, 0);
    check("inv_then_valid_busy", busy, 1);
    drive_beat(d, fill(8'd1), 0);
    wait_out();
    check("inv_then_valid_g0", grp(0), 10);
    check("ovf_cleared_narrow", b_out_overflow, 0);
    handshake();

    // reset in the middle of a 5-beat job
    run_cfg(1, lanes_of(64, 0, 0, 0), 5);
    drive_beat(fill(8'd50), fill(8'd50), 0);
    drive_beat(fill(8'd50), fill(8'd50), 0);
    rst = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_cfg_ready", cfg_ready, 1);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_data", (out_data == '0), 1);
    check("mid_rst_ngroups", out_num_groups, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_cfg(1, lanes_of(4, 0, 0, 0), 1);
    drive_beat(d, fill(8'd1), 0);
    wait_out();
    check("post_rst_latency", out_lat, 4);
    check("post_rst_g0", grp(0), 10);
    check("post_rst_ovf", out_overflow, 0);
    handshake();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
